inst_prefetch: RTL and testbench

Instruction prefetch unit for the v6502 core. It reads opcode and operand bytes from the memory read port at the fetch PC and writes them into an internal rotating byte queue. It presents the oldest three bytes to the prime decoder, which reports how many bytes it consumed each cycle. On branch or redirect it flushes the queue and restarts fetch at the new PC, discarding any in-flight response.

---
 rtl/v6502_pkg.sv | 6 +
 rtl/byte_queue.sv | 43 ++++
 rtl/inst_prefetch.sv | 94 +++++++++
 tb/tb_inst_prefetch.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/v6502_pkg.sv
// v6502_pkg: shared address width, reset PC and prefetch FSM states for the v6502 core.
package v6502_pkg;
    localparam int ADDR_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
    typedef enum logic [1:0] {PF_IDLE, PF_REQ, PF_DROP} pf_state_t;
endpackage

// File: rtl/byte_queue.sv
// byte_queue: DEPTH x 8 rotating byte queue with head/tail pointers and a three-byte peek window.
module byte_queue #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic [1:0]             pop_n,
    input  logic                   flush,
    output logic [23:0]            peek3,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(pop_n);
            r_tail  <= r_tail + PW'(push);
            r_count <= r_count + CW'(push) - CW'(pop_n);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_tail] <= push_data;
    end
    // Lanes past the valid count read zero so stale storage never leaks out.
    for (genvar g = 0; g < 3; g++) begin : g_peek
        assign peek3[8*g +: 8] = (CW'(g) < r_count) ? r_mem[r_head + PW'(g)] : 8'h00;
    end
    assign count = r_count;
endmodule

// File: rtl/inst_prefetch.sv
// inst_prefetch: fetches instruction bytes into a rotating queue and presents the oldest three
// to the decoder; redirects flush the queue and drop any stale in-flight read.
module inst_prefetch #(
    parameter int                DEPTH    = 16,
    parameter int                ADDR_W   = v6502_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = v6502_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [23:0]       q_bytes,
    output logic [2:0]        q_count,
    input  logic [1:0]        consume,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              full
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    v6502_pkg::pf_state_t r_state, w_state_nx;
    logic              r_req, w_req_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [ADDR_W-1:0] r_fetch_pc, w_fetch_nx;
    logic [ADDR_W-1:0] r_dec_pc, w_dec_nx;
    logic [CW-1:0]     w_count, w_cnt_nx;
    logic [2:0]        w_qc;
    logic [1:0]        w_pop;
    logic              w_push, w_busy;
    assign w_qc     = (w_count > CW'(3)) ? 3'd3 : w_count[2:0];
    assign w_pop    = redirect_valid ? 2'd0 : ({1'b0, consume} > w_qc) ? w_qc[1:0] : consume;
    assign w_push   = !redirect_valid && r_state == v6502_pkg::PF_REQ && r_req && mem_ack;
    assign w_busy   = r_req && !mem_ack;
    assign w_cnt_nx = w_count + CW'(w_push) - CW'(w_pop);
    always_comb begin
        w_state_nx = r_state;
        w_req_nx   = r_req;
        w_addr_nx  = r_addr;
        w_fetch_nx = r_fetch_pc + ADDR_W'(w_push);
        w_dec_nx   = r_dec_pc + ADDR_W'(w_pop);
        if (redirect_valid) begin
            w_fetch_nx = redirect_pc;
            w_dec_nx   = redirect_pc;
            w_req_nx   = 1'b1;
            w_state_nx = w_busy ? v6502_pkg::PF_DROP : v6502_pkg::PF_REQ;
            w_addr_nx  = w_busy ? r_addr : redirect_pc;
        end else if (r_state == v6502_pkg::PF_DROP) begin
            // Stale read finishes: its data is discarded and fetch restarts at the redirect PC.
            if (mem_ack) begin
                w_state_nx = v6502_pkg::PF_REQ;
                w_addr_nx  = r_fetch_pc;
            end
        end else if (!w_busy) begin
            w_req_nx   = w_cnt_nx < FULL_CNT;
            w_addr_nx  = w_fetch_nx;
            w_state_nx = w_req_nx ? v6502_pkg::PF_REQ : v6502_pkg::PF_IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= v6502_pkg::PF_REQ;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_dec_pc   <= RESET_PC;
        end else begin
            r_state    <= w_state_nx;
            r_req      <= w_req_nx;
            r_addr     <= w_addr_nx;
            r_fetch_pc <= w_fetch_nx;
            r_dec_pc   <= w_dec_nx;
        end
    end
    byte_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (mem_rdata),
        .pop_n     (w_pop),
        .flush     (redirect_valid),
        .peek3     (q_bytes),
        .count     (w_count)
    );
    assign mem_req  = r_req;
    assign mem_addr = r_addr;
    assign q_count  = w_qc;
    assign dec_pc   = r_dec_pc;
    assign fetch_pc = r_fetch_pc;
    assign full     = w_count == FULL_CNT;
endmodule

// File: tb/tb_inst_prefetch.sv
// tb_inst_prefetch: directed and random-latency checks of inst_prefetch against a reference memory.
module tb_inst_prefetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [23:0] q_bytes;
    logic [2:0]  q_count;
    logic [1:0]  consume;
    logic [15:0] dec_pc;
    logic [15:0] fetch_pc;
    logic        full;
    bit          resp_on = 1'b0;
    bit          rand_lat = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    inst_prefetch #(.DEPTH(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .q_bytes        (q_bytes),
        .q_count        (q_count),
        .consume        (consume),
        .dec_pc         (dec_pc),
        .fetch_pc       (fetch_pc),
        .full           (full)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] + a[15:8];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk)
        if (rst_n) assert ({1'b0, consume} <= q_count) else $error("FAIL consume_legal: consume %0d q_count %0d", consume, q_count);

    // Memory model: acks a request after a fixed or random latency and checks handshake stability.
    initial begin
        int   wcnt;
        int   cur_lat;
        logic prev_busy;
        logic [15:0] prev_addr;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        wcnt = 0;
        cur_lat = 1;
        prev_busy = 1'b0;
        prev_addr = 16'h0;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && prev_busy) begin
                check("addr_stable", 32'(mem_addr), 32'(prev_addr));
                check("req_held", 32'(mem_req), 32'd1);
            end
            if (resp_on && mem_req) begin
                if (wcnt + 1 >= cur_lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_byte(mem_addr);
                    wcnt = 0;
                    cur_lat = rand_lat ? int'($urandom_range(1, 5)) : 1;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                if (!mem_req) wcnt = 0;
            end
            prev_busy = mem_req && !mem_ack;
            prev_addr = mem_addr;
        end
    end

    initial begin
        logic [15:0] exp_dec;
        int exp_cnt;
        int exp_q;
        int mx;
        int c;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        consume = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'h0000);
        check("rst_qbytes", 32'(q_bytes), 32'h0);
        check("rst_qcount", 32'(q_count), 32'd0);
        check("rst_dec_pc", 32'(dec_pc), 32'h0000);
        check("rst_fetch_pc", 32'(fetch_pc), 32'h0000);
        check("rst_full", 32'(full), 32'd0);
        resp_on = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("fill_req", 32'(mem_req), 32'd1);
            check("fill_addr", 32'(mem_addr), 32'(i));
        end
        @(negedge clk);
        check("fill_full", 32'(full), 32'd1);
        check("fill_req_low", 32'(mem_req), 32'd0);
        check("fill_qbytes", 32'(q_bytes), 32'h020100);
        check("fill_qcount", 32'(q_count), 32'd3);
        check("fill_fetch_pc", 32'(fetch_pc), 32'h0010);

        resp_on = 1'b0;
        consume = 2'd3;
        @(negedge clk);
        consume = 2'd0;
        check("c3_qcount", 32'(q_count), 32'd3);
        check("c3_dec_pc", 32'(dec_pc), 32'h0003);
        check("c3_qbytes", 32'(q_bytes), 32'h050403);
        check("c3_full", 32'(full), 32'd0);
        check("c3_req", 32'(mem_req), 32'd1);
        check("c3_addr", 32'(mem_addr), 32'h0010);

        redirect_valid = 1'b1;
        redirect_pc = 16'h8000;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("drop_qcount", 32'(q_count), 32'd0);
        check("drop_dec_pc", 32'(dec_pc), 32'h8000);
        check("drop_fetch_pc", 32'(fetch_pc), 32'h8000);
        check("drop_req", 32'(mem_req), 32'd1);
        check("drop_addr", 32'(mem_addr), 32'h0010);
        repeat (2) begin
            @(negedge clk);
            check("drop_hold", 32'(mem_addr), 32'h0010);
        end
        resp_on = 1'b1;
        repeat (2) @(negedge clk);
        check("drop_new_addr", 32'(mem_addr), 32'h8000);
        check("drop_no_push", 32'(q_count), 32'd0);
        check("drop_new_req", 32'(mem_req), 32'd1);
        resp_on = 1'b0;
        @(negedge clk);
        check("new_qcount", 32'(q_count), 32'd1);
        check("new_qbytes", 32'(q_bytes), 32'h000080);
        check("new_addr", 32'(mem_addr), 32'h8001);

        resp_on = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 16'h1234;
        resp_on = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("coinc_qcount", 32'(q_count), 32'd0);
        check("coinc_qbytes", 32'(q_bytes), 32'h0);
        check("coinc_addr", 32'(mem_addr), 32'h1234);
        check("coinc_req", 32'(mem_req), 32'd1);
        check("coinc_dec_pc", 32'(dec_pc), 32'h1234);

        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFE;
        resp_on = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("wrap_drop_addr", 32'(mem_addr), 32'h1234);
        @(negedge clk);
        check("wrap_addr0", 32'(mem_addr), 32'hFFFE);
        check("wrap_q0", 32'(q_count), 32'd0);
        @(negedge clk);
        check("wrap_addr1", 32'(mem_addr), 32'hFFFF);
        check("wrap_q1", 32'(q_count), 32'd1);
        @(negedge clk);
        check("wrap_addr2", 32'(mem_addr), 32'h0000);
        check("wrap_fetch_pc", 32'(fetch_pc), 32'h0000);
        @(negedge clk);
        check("wrap_qcount", 32'(q_count), 32'd3);
        check("wrap_qbytes", 32'(q_bytes), 32'h00FEFD);
        check("wrap_dec_pc", 32'(dec_pc), 32'hFFFE);
        consume = 2'd3;
        resp_on = 1'b0;
        @(negedge clk);
        consume = 2'd0;
        check("wrap_c3_dec_pc", 32'(dec_pc), 32'h0001);
        check("wrap_c3_qcount", 32'(q_count), 32'd1);
        check("wrap_c3_qbytes", 32'(q_bytes), 32'h000001);
        check("wrap_c3_fetch_pc", 32'(fetch_pc), 32'h0002);

        exp_dec = 16'h0001;
        exp_cnt = 1;
        rand_lat = 1'b1;
        resp_on = 1'b1;
        for (int k = 0; k < 400; k++) begin
            mx = exp_cnt > 3 ? 3 : exp_cnt;
            c = (k < 200 && $urandom_range(0, 3) != 0) ? 0 : int'($urandom_range(0, mx));
            consume = 2'(c);
            exp_cnt = exp_cnt + int'(mem_ack) - c;
            exp_dec = exp_dec + 16'(c);
            @(negedge clk);
            consume = 2'd0;
            exp_q = exp_cnt > 3 ? 3 : exp_cnt;
            check("rnd_qcount", 32'(q_count), 32'(exp_q));
            check("rnd_dec_pc", 32'(dec_pc), 32'(exp_dec));
            check("rnd_fetch_pc", 32'(fetch_pc), 32'(16'(exp_dec + 16'(exp_cnt))));
            check("rnd_full", 32'(full), 32'(exp_cnt == 16));
            for (int l = 0; l < 3; l++)
                check("rnd_lane", 32'(q_bytes[8*l +: 8]), 32'(l < exp_q ? mem_byte(16'(exp_dec + 16'(l))) : 8'h00));
        end

        resp_on = 1'b0;
        @(negedge clk);
        check("mid_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_qcount", 32'(q_count), 32'd0);
        check("mid_rst_dec_pc", 32'(dec_pc), 32'h0000);
        check("mid_rst_fetch_pc", 32'(fetch_pc), 32'h0000);
        check("mid_rst_addr", 32'(mem_addr), 32'h0000);
        check("mid_rst_full", 32'(full), 32'd0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
